// File: rtl/regfile_dump_reader_if.sv
// Output stream bundle of the register-file dump reader.
// The source drives the word and its tags; the sink drives OutReady.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIndex;
  logic              OutLast;

  modport master (
    output OutValid,
    output OutData,
    output OutIndex,
    output OutLast,
    input  OutReady
  );

  modport slave (
    input  OutValid,
    input  OutData,
    input  OutIndex,
    input  OutLast,
    output OutReady
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, wrapping register range and streams snapshots out.
// Optional Abort input: define REGDUMP_ABORT_EN.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Start,
  input  logic [ADDR_W-1:0]   FirstReg,
  input  logic [ADDR_W-1:0]   LastReg,
  output logic [ADDR_W-1:0]   ReadReg,
  input  logic [DATA_W-1:0]   ReadData,
  regfile_dump_reader_if.master stream,
  output logic                Busy,
  output logic                Done
`ifdef REGDUMP_ABORT_EN
  ,
  input  logic                Abort
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] last_reg;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] idx_q;
  logic              last_q;
  logic              abort;
  logic              go;
  logic              cap;
  logic              adv;

`ifdef REGDUMP_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    cap       = 1'b0;
    adv       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          go        = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          cap       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // Abort wins over a handshake in the same cycle
        if (abort) begin
          state_nxt = IDLE;
        end else if (stream.OutReady) begin
          adv       = !last_q;
          state_nxt = last_q ? FINISH : LOAD;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      index    <= '0;
      last_reg <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (go) begin
        index    <= FirstReg;
        last_reg <= LastReg;
      end
      if (cap) begin
        data_q <= ReadData;
        idx_q  <= index;
        last_q <= (index == last_reg);
      end
      if (adv) begin
        index <= index + ADDR_W'(1);
      end
    end
  end

  assign ReadReg         = index;
  assign stream.OutValid = (state == SEND);
  assign stream.OutData  = data_q;
  assign stream.OutIndex = idx_q;
  assign stream.OutLast  = last_q;
  assign Busy            = (state != IDLE);
  assign Done            = (state == FINISH);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
// Abort scenario is built only with REGDUMP_ABORT_EN.
module tb_regfile_dump_reader;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic [4:0]  FirstReg;
  logic [4:0]  LastReg;
  logic [4:0]  ReadReg;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
`ifdef REGDUMP_ABORT_EN
  logic        Abort;
`endif

  logic [31:0] rf [32];
  int          vectors;
  int          errors;
  int          done_cnt;

  regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

  regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Start    (Start),
    .FirstReg (FirstReg),
    .LastReg  (LastReg),
    .ReadReg  (ReadReg),
    .ReadData (ReadData),
    .stream   (ifc.master),
    .Busy     (Busy),
    .Done     (Done)
`ifdef REGDUMP_ABORT_EN
    ,
    .Abort    (Abort)
`endif
  );

  assign ReadData = rf[ReadReg];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic dump(input logic [4:0] f, input logic [4:0] l,
                      input int stall_word, input int stall_n,
                      output int steps);
    logic [4:0]  span;
    logic [4:0]  idx;
    logic [31:0] exp_d;
    int          n;
    int          guard;
    span  = l - f;
    n     = int'(span) + 1;
    idx   = f;
    steps = 0;
    Start = 1'b1;
    FirstReg = f;
    LastReg  = l;
    ifc.OutReady = 1'b1;
    step();
    steps++;
    Start = 1'b0;
    chk("busy_load", 32'(Busy), 32'd1);
    chk("valid_load", 32'(ifc.OutValid), 32'd0);
    for (int k = 0; k < n; k++) begin
      guard = 0;
      while (!ifc.OutValid && guard < 8) begin
        step();
        steps++;
        guard++;
      end
      exp_d = rf[idx];
      chk("valid", 32'(ifc.OutValid), 32'd1);
      chk("index", 32'(ifc.OutIndex), 32'(idx));
      chk("data", ifc.OutData, exp_d);
      chk("last", 32'(ifc.OutLast), 32'(k == n - 1));
      if (k == stall_word) begin
        ifc.OutReady = 1'b0;
        rf[idx] = 32'h12345678;
        for (int s = 0; s < stall_n; s++) begin
          step();
          steps++;
          chk("stall_valid", 32'(ifc.OutValid), 32'd1);
          chk("stall_data", ifc.OutData, exp_d);
          chk("stall_index", 32'(ifc.OutIndex), 32'(idx));
        end
        ifc.OutReady = 1'b1;
      end
      step();
      steps++;
      idx = idx + 5'd1;
    end
    chk("done_pulse", 32'(Done), 32'd1);
    step();
    chk("done_clear", 32'(Done), 32'd0);
    chk("busy_clear", 32'(Busy), 32'd0);
  endtask

  initial begin
    int st;
    int dc;
    vectors  = 0;
    errors   = 0;
    done_cnt = 0;
    Resetn   = 1'b0;
    Start    = 1'b0;
    FirstReg = '0;
    LastReg  = '0;
    ifc.OutReady = 1'b0;
`ifdef REGDUMP_ABORT_EN
    Abort = 1'b0;
`endif
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 4);
    rf[5] = 32'hDEADBEEF;
    #12;
    chk("rst_readreg", 32'(ReadReg), 32'd0);
    chk("rst_valid", 32'(ifc.OutValid), 32'd0);
    chk("rst_data", ifc.OutData, 32'd0);
    chk("rst_index", 32'(ifc.OutIndex), 32'd0);
    chk("rst_last", 32'(ifc.OutLast), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    #10;
    Resetn = 1'b1;
    step();

    dump(5'd5, 5'd5, -1, 0, st);
    chk("single_steps", 32'(st), 32'd3);
    chk("single_data", ifc.OutData, 32'hDEADBEEF);

    rf[5] = 32'd20;
    dump(5'd0, 5'd31, -1, 0, st);
    chk("full_steps", 32'(st), 32'd65);

    dump(5'd30, 5'd1, -1, 0, st);
    chk("wrap_steps", 32'(st), 32'd9);
    chk("wrap_index", 32'(ifc.OutIndex), 32'd1);

    dump(5'd0, 5'd31, 2, 5, st);
    chk("stall_steps", 32'(st), 32'd70);
    chk("stall_rf", rf[2], 32'h12345678);
    rf[2] = 32'd8;

    dc = done_cnt;
    Start = 1'b1;
    FirstReg = 5'd0;
    LastReg  = 5'd31;
    ifc.OutReady = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    Start = 1'b1;
    FirstReg = 5'd20;
    LastReg  = 5'd20;
    step();
    Start = 1'b0;
    chk("ign_valid", 32'(ifc.OutValid), 32'd1);
    chk("ign_index", 32'(ifc.OutIndex), 32'd1);
    chk("ign_data", ifc.OutData, 32'd4);
    ifc.OutReady = 1'b0;
    step();
    Resetn = 1'b0;
    #1;
    chk("mid_readreg", 32'(ReadReg), 32'd0);
    chk("mid_valid", 32'(ifc.OutValid), 32'd0);
    chk("mid_data", ifc.OutData, 32'd0);
    chk("mid_index", 32'(ifc.OutIndex), 32'd0);
    chk("mid_busy", 32'(Busy), 32'd0);
    chk("mid_done", 32'(Done), 32'd0);
    step();
    step();
    Resetn = 1'b1;
    step();
    step();
    step();
    chk("mid_no_done", 32'(done_cnt), 32'(dc));
    chk("mid_idle", 32'(Busy), 32'd0);

`ifdef REGDUMP_ABORT_EN
    dc = done_cnt;
    Start = 1'b1;
    FirstReg = 5'd0;
    LastReg  = 5'd31;
    ifc.OutReady = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < 4 && !ifc.OutValid; g++) step();
      step();
    end
    for (int g = 0; g < 4 && !ifc.OutValid; g++) step();
    chk("ab_index", 32'(ifc.OutIndex), 32'd3);
    chk("ab_valid_pre", 32'(ifc.OutValid), 32'd1);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("ab_valid", 32'(ifc.OutValid), 32'd0);
    chk("ab_busy", 32'(Busy), 32'd0);
    step();
    step();
    chk("ab_no_done", 32'(done_cnt), 32'(dc));
    dump(5'd7, 5'd8, -1, 0, st);
    chk("ab_restart_steps", 32'(st), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
